// File: rtl/pump_drive_pkg.sv
// rtl/pump_drive_pkg.sv - shared types and timing helpers for the pump drive sequencer
package pump_drive_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        VALVE_LEAD = 3'd1,
        RAMP       = 3'd2,
        RUN        = 3'd3,
        HOLDOFF    = 3'd4
    } seq_state_t;

    function automatic int unsigned pwm_max(input int unsigned bits);
        return (1 << bits) - 1;
    endfunction

    function automatic int unsigned cycles_per_ms(input int unsigned clk_hz);
        return (clk_hz / 1000 < 1) ? 1 : clk_hz / 1000;
    endfunction

    // Number of clock cycles spanned by a duration in ms.
    function automatic int unsigned ms_to_ticks(input int unsigned clk_hz, input int unsigned ms);
        return (clk_hz / 1000) * ms;
    endfunction

    function automatic int unsigned ramp_step(input int unsigned clk_hz, input int unsigned ramp_ms,
                                              input int unsigned bits);
        int unsigned step;
        step = ms_to_ticks(clk_hz, ramp_ms) / pwm_max(bits);
        return (step < 1) ? 1 : step;
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - free-running PWM counter with registered duty comparator
module pwm_gen
    import pump_drive_pkg::*;
#(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pwm
);

    // Period of PWM_MAX counts so that duty == PWM_MAX yields a solid high.
    localparam logic [PWM_BITS-1:0] CNT_TOP = PWM_BITS'(pwm_max(PWM_BITS) - 1);

    logic [PWM_BITS-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            pwm <= 1'b0;
        end else begin
            cnt <= (cnt == CNT_TOP) ? '0 : cnt + PWM_BITS'(1);
            pwm <= (cnt < duty);
        end
    end

endmodule

// File: rtl/pump_drive_sequencer.sv
// rtl/pump_drive_sequencer.sv - valve-first pump soft-start sequencer with min-on, hold-off and fault override
module pump_drive_sequencer
    import pump_drive_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 100_000_000,
    parameter int unsigned VALVE_LEAD_MS = 50,
    parameter int unsigned RAMP_MS       = 255,
    parameter int unsigned MIN_ON_MS     = 1000,
    parameter int unsigned MIN_OFF_MS    = 2000,
    parameter int unsigned PWM_BITS      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pump_req,
    input  logic                valve_req,
    input  logic                fault_in,
    output logic                pump_pwm,
    output logic                valve_open,
    output logic [PWM_BITS-1:0] duty,
    output logic [2:0]          seq_state,
    output logic                running
);

    localparam int unsigned TICK_DIV  = cycles_per_ms(CLK_HZ);
    localparam int unsigned RAMP_STEP = ramp_step(CLK_HZ, RAMP_MS, PWM_BITS);
    localparam int unsigned T_MAX01   = (VALVE_LEAD_MS > MIN_ON_MS) ? VALVE_LEAD_MS : MIN_ON_MS;
    localparam int unsigned T_MAX     = (T_MAX01 > MIN_OFF_MS) ? T_MAX01 : MIN_OFF_MS;
    localparam int TW = $clog2(T_MAX + 1);
    localparam int PW = $clog2(TICK_DIV + 1);
    localparam int SW = $clog2(RAMP_STEP + 1);

    localparam logic [TW-1:0]       LEAD_T    = TW'(VALVE_LEAD_MS);
    localparam logic [TW-1:0]       ON_T      = TW'(MIN_ON_MS);
    localparam logic [TW-1:0]       OFF_T     = TW'(MIN_OFF_MS);
    localparam logic [PW-1:0]       PRESC_TOP = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0]       STEP_TOP  = SW'(RAMP_STEP - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX  = PWM_BITS'(pwm_max(PWM_BITS));

    logic [1:0]          rst_sync;
    logic                rst_int;
    logic [PW-1:0]       presc;
    logic                tick;
    seq_state_t          state, state_next;
    logic [TW-1:0]       timer, timer_next, timer_inc, term;
    logic [SW-1:0]       step_cnt, step_next;
    logic [PWM_BITS-1:0] duty_next;
    logic                valve_next, running_next, stop_ok;

    // Asserts with rst_n immediately, releases two clocks later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int = rst_sync[1];

    assign tick      = (presc == PRESC_TOP);
    assign seq_state = state;
    assign stop_ok   = !pump_req && (timer >= ON_T);

    // One shared timer; its meaning and terminal value depend on the state.
    always_comb begin
        term = '0;
        case (state)
            VALVE_LEAD: term = LEAD_T;
            RAMP, RUN:  term = ON_T;
            HOLDOFF:    term = OFF_T;
            default:    term = '0;
        endcase
        timer_inc = (tick && timer < term) ? timer + TW'(1) : timer;
    end

    always_comb begin
        state_next   = state;
        timer_next   = timer_inc;
        step_next    = '0;
        duty_next    = duty;
        valve_next   = valve_open;
        case (state)
            IDLE: begin
                timer_next = '0;
                duty_next  = '0;
                valve_next = valve_req && !fault_in;
                if (pump_req && !fault_in) begin
                    state_next = VALVE_LEAD;
                    valve_next = 1'b1;
                end
            end
            VALVE_LEAD: begin
                duty_next  = '0;
                valve_next = 1'b1;
                if (!pump_req) begin
                    state_next = HOLDOFF;
                    timer_next = '0;
                    valve_next = 1'b0;
                end else if (timer_inc >= LEAD_T) begin
                    state_next = RAMP;
                    timer_next = '0;
                end
            end
            RAMP: begin
                valve_next = 1'b1;
                if (stop_ok) begin
                    state_next = HOLDOFF;
                    timer_next = '0;
                    duty_next  = '0;
                    valve_next = 1'b0;
                end else if (step_cnt == STEP_TOP) begin
                    duty_next = duty + PWM_BITS'(1);
                    if (duty_next == DUTY_MAX) state_next = RUN;
                end else begin
                    step_next = step_cnt + SW'(1);
                end
            end
            RUN: begin
                duty_next  = DUTY_MAX;
                valve_next = 1'b1;
                if (stop_ok) begin
                    state_next = HOLDOFF;
                    timer_next = '0;
                    duty_next  = '0;
                    valve_next = 1'b0;
                end
            end
            HOLDOFF: begin
                duty_next  = '0;
                valve_next = valve_req && !fault_in;
                if (fault_in) begin
                    timer_next = '0;
                end else if (timer_inc >= OFF_T) begin
                    state_next = IDLE;
                    timer_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
                duty_next  = '0;
                valve_next = 1'b0;
            end
        endcase
        // Fault beats min-on and any pending request.
        if (fault_in && state != IDLE) begin
            state_next = HOLDOFF;
            timer_next = '0;
            step_next  = '0;
            duty_next  = '0;
            valve_next = 1'b0;
        end
        running_next = (state == RUN) && (state_next == RUN);
    end

    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            presc      <= '0;
            state      <= IDLE;
            timer      <= '0;
            step_cnt   <= '0;
            duty       <= '0;
            valve_open <= 1'b0;
            running    <= 1'b0;
        end else begin
            presc      <= tick ? '0 : presc + PW'(1);
            state      <= state_next;
            timer      <= timer_next;
            step_cnt   <= step_next;
            duty       <= duty_next;
            valve_open <= valve_next;
            running    <= running_next;
        end
    end

    // Compare against the next duty so the PWM output changes together with duty.
    pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
        .clk   (clk),
        .rst_n (rst_int),
        .duty  (duty_next),
        .pwm   (pump_pwm)
    );

endmodule

// File: tb/tb_pump_drive_sequencer.sv
// tb/tb_pump_drive_sequencer.sv - directed self-checking bench for pump_drive_sequencer
module tb_pump_drive_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pump_req = 1'b0;
    logic       valve_req = 1'b0;
    logic       fault_in = 1'b0;
    logic       pump_pwm;
    logic       valve_open;
    logic [7:0] duty;
    logic [2:0] seq_state;
    logic       running;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] S_IDLE = 3'd0, S_LEAD = 3'd1, S_RAMP = 3'd2, S_RUN = 3'd3, S_HOLD = 3'd4;

    pump_drive_sequencer #(
        .CLK_HZ(1000), .VALVE_LEAD_MS(4), .RAMP_MS(255),
        .MIN_ON_MS(300), .MIN_OFF_MS(20), .PWM_BITS(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pump_req(pump_req), .valve_req(valve_req),
        .fault_in(fault_in), .pump_pwm(pump_pwm), .valve_open(valve_open),
        .duty(duty), .seq_state(seq_state), .running(running)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; pump_req = 1'b0; valve_req = 1'b0; fault_in = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) step();
        checks++; if (seq_state !== S_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", seq_state, S_IDLE); end
        checks++; if (duty !== 8'd0) begin errors++; $display("FAIL reset_duty got=%0d exp=0", duty); end
        checks++; if (pump_pwm !== 1'b0) begin errors++; $display("FAIL reset_pwm got=%0d exp=0", pump_pwm); end
        checks++; if (valve_open !== 1'b0) begin errors++; $display("FAIL reset_valve got=%0d exp=0", valve_open); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got=%0d exp=0", running); end
        rst_n = 1'b1;
        repeat (3) step();
        checks++; if (seq_state !== S_IDLE) begin errors++; $display("FAIL post_reset_idle got=%0d exp=%0d", seq_state, S_IDLE); end
    endtask

    task automatic test_normal_start();
        pump_req = 1'b1;
        step();
        checks++; if (valve_open !== 1'b1) begin errors++; $display("FAIL start_valve got=%0d exp=1", valve_open); end
        checks++; if (seq_state !== S_LEAD) begin errors++; $display("FAIL start_lead got=%0d exp=%0d", seq_state, S_LEAD); end
        checks++; if (duty !== 8'd0) begin errors++; $display("FAIL start_duty c1 got=%0d exp=0", duty); end
        for (int c = 2; c <= 5; c++) begin
            step();
            checks++; if (duty !== 8'd0) begin errors++; $display("FAIL lead_duty c%0d got=%0d exp=0", c, duty); end
            checks++; if (seq_state !== ((c == 5) ? S_RAMP : S_LEAD)) begin errors++; $display("FAIL lead_state c%0d got=%0d", c, seq_state); end
        end
        for (int k = 1; k <= 255; k++) begin
            step();
            checks++; if (duty !== 8'(k)) begin errors++; $display("FAIL ramp_duty got=%0d exp=%0d", duty, k); end
        end
        checks++; if (seq_state !== S_RUN) begin errors++; $display("FAIL run_entry got=%0d exp=%0d", seq_state, S_RUN); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL running_early got=%0d exp=0", running); end
        step();
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL running_late got=%0d exp=1", running); end
        for (int i = 0; i < 260; i++) begin
            step();
            checks++; if (pump_pwm !== 1'b1 || seq_state !== S_RUN) begin errors++; $display("FAIL run_pwm i=%0d pwm=%0d state=%0d exp pwm=1 state=3", i, pump_pwm, seq_state); end
        end
    endtask

    task automatic test_min_on_deferral();
        do_reset();
        pump_req = 1'b1;
        repeat (5) step();
        checks++; if (seq_state !== S_RAMP || duty !== 8'd0) begin errors++; $display("FAIL ramp_entry state=%0d duty=%0d exp 2/0", seq_state, duty); end
        repeat (100) step();
        checks++; if (duty !== 8'd100) begin errors++; $display("FAIL defer_duty100 got=%0d exp=100", duty); end
        pump_req = 1'b0;
        step();
        checks++; if (seq_state !== S_RAMP || duty !== 8'd101) begin errors++; $display("FAIL defer_continue state=%0d duty=%0d exp 2/101", seq_state, duty); end
        repeat (154) step();
        checks++; if (seq_state !== S_RUN || duty !== 8'd255) begin errors++; $display("FAIL defer_run state=%0d duty=%0d exp 3/255", seq_state, duty); end
        repeat (45) step();
        checks++; if (seq_state !== S_RUN || valve_open !== 1'b1) begin errors++; $display("FAIL defer_hold state=%0d valve=%0d exp 3/1", seq_state, valve_open); end
        step();
        checks++; if (seq_state !== S_HOLD) begin errors++; $display("FAIL stop_state got=%0d exp=%0d", seq_state, S_HOLD); end
        checks++; if (duty !== 8'd0) begin errors++; $display("FAIL stop_duty got=%0d exp=0", duty); end
        checks++; if (valve_open !== 1'b0) begin errors++; $display("FAIL stop_valve got=%0d exp=0", valve_open); end
        checks++; if (running !== 1'b0 || pump_pwm !== 1'b0) begin errors++; $display("FAIL stop_drive running=%0d pwm=%0d exp 0/0", running, pump_pwm); end
    endtask

    task automatic test_anti_short_cycle();
        pump_req = 1'b1;
        for (int i = 1; i < 20; i++) begin
            step();
            checks++; if (seq_state !== S_HOLD) begin errors++; $display("FAIL holdoff_state i=%0d got=%0d exp=%0d", i, seq_state, S_HOLD); end
        end
        step();
        checks++; if (seq_state !== S_IDLE) begin errors++; $display("FAIL holdoff_exit got=%0d exp=%0d", seq_state, S_IDLE); end
        step();
        checks++; if (seq_state !== S_LEAD) begin errors++; $display("FAIL restart_lead got=%0d exp=%0d", seq_state, S_LEAD); end
    endtask

    task automatic test_fault_override();
        int n;
        n = 0;
        while (duty !== 8'd100 && n < 400) begin step(); n++; end
        checks++; if (duty !== 8'd100 || seq_state !== S_RAMP) begin errors++; $display("FAIL fault_setup duty=%0d state=%0d exp 100/2", duty, seq_state); end
        fault_in = 1'b1; valve_req = 1'b1;
        step();
        checks++; if (seq_state !== S_HOLD) begin errors++; $display("FAIL fault_state got=%0d exp=%0d", seq_state, S_HOLD); end
        checks++; if (duty !== 8'd0) begin errors++; $display("FAIL fault_duty got=%0d exp=0", duty); end
        checks++; if (pump_pwm !== 1'b0) begin errors++; $display("FAIL fault_pwm got=%0d exp=0", pump_pwm); end
        checks++; if (valve_open !== 1'b0) begin errors++; $display("FAIL fault_valve got=%0d exp=0", valve_open); end
        for (int i = 1; i < 50; i++) begin
            step();
            checks++; if (seq_state !== S_HOLD || valve_open !== 1'b0) begin errors++; $display("FAIL fault_hold i=%0d state=%0d valve=%0d exp 4/0", i, seq_state, valve_open); end
        end
        fault_in = 1'b0; valve_req = 1'b0; pump_req = 1'b0;
        for (int i = 1; i < 20; i++) begin
            step();
            checks++; if (seq_state !== S_HOLD) begin errors++; $display("FAIL fault_release i=%0d got=%0d exp=%0d", i, seq_state, S_HOLD); end
        end
        step();
        checks++; if (seq_state !== S_IDLE) begin errors++; $display("FAIL fault_idle got=%0d exp=%0d", seq_state, S_IDLE); end
    endtask

    task automatic test_manual_flush();
        valve_req = 1'b1;
        step();
        checks++; if (valve_open !== 1'b1 || seq_state !== S_IDLE) begin errors++; $display("FAIL flush_open valve=%0d state=%0d exp 1/0", valve_open, seq_state); end
        repeat (10) step();
        checks++; if (pump_pwm !== 1'b0 || valve_open !== 1'b1) begin errors++; $display("FAIL flush_pwm pwm=%0d valve=%0d exp 0/1", pump_pwm, valve_open); end
        fault_in = 1'b1; pump_req = 1'b1;
        step();
        checks++; if (valve_open !== 1'b0) begin errors++; $display("FAIL flush_fault_valve got=%0d exp=0", valve_open); end
        step();
        checks++; if (seq_state !== S_IDLE) begin errors++; $display("FAIL fault_wins got=%0d exp=%0d", seq_state, S_IDLE); end
        fault_in = 1'b0; pump_req = 1'b0; valve_req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        int n;
        pump_req = 1'b1;
        n = 0;
        while (running !== 1'b1 && n < 400) begin step(); n++; end
        checks++; if (running !== 1'b1 || seq_state !== S_RUN) begin errors++; $display("FAIL rst_setup running=%0d state=%0d exp 1/3", running, seq_state); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (duty !== 8'd0 || pump_pwm !== 1'b0) begin errors++; $display("FAIL async_drive duty=%0d pwm=%0d exp 0/0", duty, pump_pwm); end
        checks++; if (valve_open !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL async_valve valve=%0d running=%0d exp 0/0", valve_open, running); end
        checks++; if (seq_state !== S_IDLE) begin errors++; $display("FAIL async_state got=%0d exp=%0d", seq_state, S_IDLE); end
        step(); step();
        rst_n = 1'b1;
        checks++; if (seq_state !== S_IDLE) begin errors++; $display("FAIL rst_release got=%0d exp=%0d", seq_state, S_IDLE); end
        n = 0;
        while (seq_state !== S_LEAD && n < 30) begin step(); n++; end
        checks++; if (seq_state !== S_LEAD || n > 4) begin errors++; $display("FAIL rst_no_holdoff state=%0d cycles=%0d exp 1 within 4", seq_state, n); end
        checks++; if (valve_open !== 1'b1) begin errors++; $display("FAIL rst_restart_valve got=%0d exp=1", valve_open); end
    endtask

    initial begin
        test_reset();
        test_normal_start();
        test_min_on_deferral();
        test_anti_short_cycle();
        test_fault_override();
        test_manual_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pump_drive_sequencer.md
Name: pump_drive_sequencer

Overview:
- Downstream of the pump controller: consumes its pump-on request, valve request and latched-fault flag.
- Drives the physical pump (PWM soft-start) and the solenoid valve with safe sequencing: valve opens first, pump duty ramps up, minimum run time, anti-short-cycle hold-off.
- A fault overrides everything within one clock.

Parameters:
CLK_HZ, 100_000_000, system clock frequency; one ms tick every CLK_HZ/1000 cycles (minimum 1).
VALVE_LEAD_MS, 50, time the valve is open before the pump ramp starts.
RAMP_MS, 255, soft-start duration from duty 0 to full duty.
MIN_ON_MS, 1000, minimum time from ramp start before a normal stop is honoured.
MIN_OFF_MS, 2000, hold-off after any stop or fault before a new start.
PWM_BITS, 8, duty and PWM counter width.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pump_req  in  1  run request from the pump controller (level)
valve_req  in  1  valve request; honoured only while IDLE/HOLDOFF (manual flush), ignored otherwise
fault_in  in  1  latched fault from the controller; forces immediate stop
pump_pwm  out  1  PWM drive to the pump MOSFET
valve_open  out  1  solenoid drive
duty  out  PWM_BITS  current duty value
seq_state  out  3  state encoding (see package)
running  out  1  high only in RUN (full duty reached)

Behaviour:
- Reset (async assert, sync deassert internally): state=IDLE; duty=0, pump_pwm=0, valve_open=0, running=0; all timers and the PWM counter cleared. Reset mid-ramp or mid-holdoff returns to IDLE with no hold-off.
- Tick: prescaler pulses `tick` for 1 cycle every CLK_HZ/1000 cycles. All ms timers count ticks.
- PWM: free-running counter 0..2^PWM_BITS-2, wrapping to 0.
  - pump_pwm = (cnt < duty), registered.
  - duty = 2^PWM_BITS-1 gives 100% on; duty=0 gives always off.
- States: IDLE(0), VALVE_LEAD(1), RAMP(2), RUN(3), HOLDOFF(4).
- IDLE:
  - valve_open=valve_req.
  - pump_req=1 and fault_in=0 -> VALVE_LEAD: valve_open=1, lead timer cleared.
- VALVE_LEAD:
  - valve_open=1, duty=0.
  - After VALVE_LEAD_MS ticks -> RAMP; min-on timer cleared.
  - pump_req drop here -> HOLDOFF (valve closes the next cycle).
- RAMP:
  - duty += 1 every RAMP_STEP cycles, where RAMP_STEP = max(1, (CLK_HZ/1000*RAMP_MS)/(2^PWM_BITS-1)).
  - Duty saturates at 2^PWM_BITS-1 -> RUN; running=1 on the cycle after the transition.
- RUN: duty=max, valve_open=1.
- Normal stop (pump_req=0 in RAMP or RUN):
  - Honoured only once the min-on timer has reached MIN_ON_MS. Until then the request is deferred; the ramp continues or RUN holds.
  - When honoured: duty=0 and valve_open=0 on the next cycle, running=0, -> HOLDOFF.
- HOLDOFF:
  - Pump off; valve_open=valve_req.
  - After MIN_OFF_MS ticks -> IDLE.
  - pump_req during HOLDOFF is ignored, not queued. IDLE re-evaluates the request afterwards.
- fault_in=1 in any state other than IDLE:
  - Next cycle: duty=0, pump_pwm=0, valve_open=0, running=0, state=HOLDOFF; timers restart. This overrides min-on.
  - While fault_in stays 1, HOLDOFF's timer is held at 0 and valve_req is ignored.
- fault_in=1 in IDLE: stay IDLE, valve forced closed.
- Simultaneous fault_in and pump_req: fault wins.
- Timer widths are derived via $clog2 of the maximum count plus 1. No timer wraps; each saturates at its terminal value.

Decomposition:
- Package pump_drive_pkg holds:
  - seq_state_t enum (3-bit, values above);
  - function ms_to_ticks and the RAMP_STEP computation;
  - PWM_MAX localparam helper.
- One sub-module: pwm_gen (counter plus comparator, parameter PWM_BITS, inputs clk/rst_n/duty, output pwm).
- FSM, tick prescaler and timers stay in the top module.

Test Plan:
- Common setup: CLK_HZ=1000 (tick every cycle), VALVE_LEAD_MS=4, RAMP_MS=255 (duty +1 per cycle), MIN_ON_MS=300, MIN_OFF_MS=20.
- Normal start: pump_req=1 at cycle 0 -> valve_open=1 at cycle 1, duty stays 0 for 4 cycles, then rises by 1 per cycle, reaches 255 and state=RUN; running=1 the next cycle; pump_pwm is constantly 1 in RUN.
- Min-on deferral: drop pump_req 100 cycles into RAMP -> duty keeps rising; stop occurs when the min-on timer reaches 300, then duty=0, valve_open=0, state=HOLDOFF.
- Anti-short-cycle: after a stop, re-assert pump_req immediately -> state stays HOLDOFF for 20 cycles, then IDLE, then VALVE_LEAD on the next cycle.
- Fault override: fault_in=1 mid-RAMP at duty=100 -> next cycle duty=0, pump_pwm=0, valve_open=0, state=HOLDOFF. Hold fault for 50 cycles -> still HOLDOFF. Release fault -> IDLE after 20 more cycles.
- Manual flush: in IDLE with pump_req=0, valve_req=1 -> valve_open=1 and pump_pwm stays 0. Then assert fault_in -> valve_open=0.
- Reset mid-operation: assert rst_n=0 while in RUN -> outputs go to 0 asynchronously (before the next clk edge). After release, state=IDLE and a start needs no hold-off.
